// File: rtl/sm_dm_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: grant state encoding and
// lock counter width.
package sm_dmarb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } dmarb_state_e;

  localparam int unsigned LOCK_CW = 4;

endpackage

// File: rtl/sm_dm_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker. On a tie the requester that did
// not own the resource last wins; otherwise the sole requester is picked.
module sm_rr_pick2 (
  input  logic [1:0] req_i,
  input  logic       lastOwner_i,
  output logic       valid_o,
  output logic       pick_o
);

  // Tie goes to the opposite of the last owner; pick_o=1 selects requester 1.
  always_comb begin
    valid_o = |req_i;
    pick_o  = (req_i == 2'b11) ? ~lastOwner_i : req_i[1];
  end

endmodule

// File: rtl/sm_dm_arbiter.sv
// Two-core data-memory arbiter: round-robin shares one single-port RAM
// (sync write, async read) between two cpu data ports with a req/ready
// handshake. Optional bus lock enabled by defining SM_DMARB_LOCK_EN.
import sm_dmarb_pkg::*;

module sm_dm_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int LOCK_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          c0Req,
  input  logic          c0We,
  input  logic [AW-1:0] c0Addr,
  input  logic [DW-1:0] c0WData,
  output logic [DW-1:0] c0RData,
  output logic          c0Ready,
  input  logic          c1Req,
  input  logic          c1We,
  input  logic [AW-1:0] c1Addr,
  input  logic [DW-1:0] c1WData,
  output logic [DW-1:0] c1RData,
  output logic          c1Ready,
`ifdef SM_DMARB_LOCK_EN
  input  logic          c0Lock,
  input  logic          c1Lock,
`endif
  output logic [AW-1:0] mAddr,
  output logic          mWe,
  output logic [DW-1:0] mWData,
  input  logic [DW-1:0] mRData
);

  if (LOCK_MAX < 1 || LOCK_MAX > (2 ** LOCK_CW) - 1) begin : g_bad_lock_max
    $error("sm_dm_arbiter: LOCK_MAX out of range");
  end

  dmarb_state_e state_q, state_d;
  logic         lastOwner_q, lastOwner_d;
  logic         pickValid, pickSel;
  logic         hold0, hold1;

`ifdef SM_DMARB_LOCK_EN
  logic [LOCK_CW-1:0] lockCnt_q, lockCnt_d;

  // A lock keeps the grant only until the hold budget is used up.
  always_comb begin
    hold0 = c0Lock && (lockCnt_q < LOCK_CW'(LOCK_MAX - 1));
    hold1 = c1Lock && (lockCnt_q < LOCK_CW'(LOCK_MAX - 1));
  end
`else
  // Without the lock feature a grant never extends past one cycle.
  always_comb begin
    hold0 = 1'b0;
    hold1 = 1'b0;
  end
`endif

  sm_rr_pick2 u_pick (
    .req_i       ({c1Req, c0Req}),
    .lastOwner_i (lastOwner_q),
    .valid_o     (pickValid),
    .pick_o      (pickSel)
  );

  // Grant state, round-robin history and lock counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      lastOwner_q <= 1'b1;
`ifdef SM_DMARB_LOCK_EN
      lockCnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      lastOwner_q <= lastOwner_d;
`ifdef SM_DMARB_LOCK_EN
      lockCnt_q   <= lockCnt_d;
`endif
    end
  end

  // Next-state: the current owner's own request is ignored on exit, so it
  // has to win arbitration again from IDLE or via the other core's grant.
  always_comb begin
    state_d     = state_q;
    lastOwner_d = lastOwner_q;
`ifdef SM_DMARB_LOCK_EN
    lockCnt_d   = lockCnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (pickValid) begin
          state_d = pickSel ? GNT1 : GNT0;
        end
`ifdef SM_DMARB_LOCK_EN
        lockCnt_d = '0;
`endif
      end
      GNT0: begin
        if (hold0) begin
          state_d = GNT0;
`ifdef SM_DMARB_LOCK_EN
          lockCnt_d = lockCnt_q + 1'b1;
`endif
        end else begin
          lastOwner_d = 1'b0;
          state_d     = c1Req ? GNT1 : IDLE;
`ifdef SM_DMARB_LOCK_EN
          lockCnt_d   = '0;
`endif
        end
      end
      GNT1: begin
        if (hold1) begin
          state_d = GNT1;
`ifdef SM_DMARB_LOCK_EN
          lockCnt_d = lockCnt_q + 1'b1;
`endif
        end else begin
          lastOwner_d = 1'b1;
          state_d     = c0Req ? GNT0 : IDLE;
`ifdef SM_DMARB_LOCK_EN
          lockCnt_d   = '0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Memory and core-side outputs are decoded purely from the grant state.
  always_comb begin
    mAddr   = '0;
    mWData  = '0;
    mWe     = 1'b0;
    c0Ready = 1'b0;
    c1Ready = 1'b0;
    c0RData = '0;
    c1RData = '0;
    unique case (state_q)
      GNT0: begin
        mAddr   = c0Addr;
        mWData  = c0WData;
        mWe     = c0Req & c0We;
        c0Ready = c0Req;
        c0RData = mRData;
      end
      GNT1: begin
        mAddr   = c1Addr;
        mWData  = c1WData;
        mWe     = c1Req & c1We;
        c1Ready = c1Req;
        c1RData = mRData;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sm_dm_arbiter.sv
// Directed self-checking bench for sm_dm_arbiter with a small behavioural
// RAM (sync write, async read) hanging off the memory port.
module tb_sm_dm_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        c0Req, c0We, c1Req, c1We;
  logic [31:0] c0Addr, c0WData, c1Addr, c1WData;
  logic [31:0] c0RData, c1RData;
  logic        c0Ready, c1Ready;
  logic [31:0] mAddr, mWData, mRData;
  logic        mWe;
`ifdef SM_DMARB_LOCK_EN
  logic        c0Lock, c1Lock;
`endif

  logic [31:0] mem [0:63];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mWe) mem[mAddr[7:2]] <= mWData;
  end
  assign mRData = mem[mAddr[7:2]];

  sm_dm_arbiter #(.AW(32), .DW(32), .LOCK_MAX(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .c0Req   (c0Req),
    .c0We    (c0We),
    .c0Addr  (c0Addr),
    .c0WData (c0WData),
    .c0RData (c0RData),
    .c0Ready (c0Ready),
    .c1Req   (c1Req),
    .c1We    (c1We),
    .c1Addr  (c1Addr),
    .c1WData (c1WData),
    .c1RData (c1RData),
    .c1Ready (c1Ready),
`ifdef SM_DMARB_LOCK_EN
    .c0Lock  (c0Lock),
    .c1Lock  (c1Lock),
`endif
    .mAddr   (mAddr),
    .mWe     (mWe),
    .mWData  (mWData),
    .mRData  (mRData)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    rst = 1'b1;
    c0Req = 0; c0We = 0; c0Addr = '0; c0WData = '0;
    c1Req = 0; c1We = 0; c1Addr = '0; c1WData = '0;
`ifdef SM_DMARB_LOCK_EN
    c0Lock = 0; c1Lock = 0;
`endif

    // Reset values
    @(negedge clk);
    chk("rst_c0Ready", {31'd0, c0Ready}, 32'd0);
    chk("rst_c1Ready", {31'd0, c1Ready}, 32'd0);
    chk("rst_mWe", {31'd0, mWe}, 32'd0);
    chk("rst_mAddr", mAddr, 32'd0);
    chk("rst_mWData", mWData, 32'd0);
    chk("rst_c0RData", c0RData, 32'd0);
    chk("rst_c1RData", c1RData, 32'd0);
    next_cycle();
    rst = 1'b0;

    // Core0 write of 0xDEADBEEF to 0x10, then core1 reads it back
    next_cycle();
    c0Req = 1; c0We = 1; c0Addr = 32'h10; c0WData = 32'hDEADBEEF;
    @(negedge clk);
    chk("wr_idle_c0Ready", {31'd0, c0Ready}, 32'd0);
    chk("wr_idle_mWe", {31'd0, mWe}, 32'd0);
    next_cycle();
    @(negedge clk);
    chk("wr_gnt_mWe", {31'd0, mWe}, 32'd1);
    chk("wr_gnt_mAddr", mAddr, 32'h10);
    chk("wr_gnt_mWData", mWData, 32'hDEADBEEF);
    chk("wr_gnt_c0Ready", {31'd0, c0Ready}, 32'd1);
    chk("wr_gnt_c1Ready", {31'd0, c1Ready}, 32'd0);
    next_cycle();
    c0Req = 0; c0We = 0;
    c1Req = 1; c1We = 0; c1Addr = 32'h10;
    chk("wr_mem_0x10", mem[4], 32'hDEADBEEF);
    @(negedge clk);
    chk("rd_idle_c1Ready", {31'd0, c1Ready}, 32'd0);
    next_cycle();
    @(negedge clk);
    chk("rd_gnt_c1Ready", {31'd0, c1Ready}, 32'd1);
    chk("rd_gnt_c1RData", c1RData, 32'hDEADBEEF);
    chk("rd_gnt_c0RData", c0RData, 32'd0);
    chk("rd_gnt_mWe", {31'd0, mWe}, 32'd0);
    next_cycle();
    c1Req = 0;

    // Contention: strict alternation starting with core0 (last owner was 1)
    c0Req = 1; c0Addr = 32'h10; c1Req = 1; c1Addr = 32'h14;
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      @(negedge clk);
      chk($sformatf("alt%0d_c0Ready", i), {31'd0, c0Ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("alt%0d_c1Ready", i), {31'd0, c1Ready}, (i % 2 == 0) ? 32'd0 : 32'd1);
      chk($sformatf("alt%0d_both", i), {31'd0, c0Ready & c1Ready}, 32'd0);
      if (i % 2 == 0) chk($sformatf("alt%0d_c0RData", i), c0RData, 32'hDEADBEEF);
      if (i == 4) begin
        c0Req = 0; c1Req = 0;
      end
    end
    next_cycle();

    // Reset in the middle of a core1 write grant
    c1Req = 1; c1We = 1; c1Addr = 32'h20; c1WData = 32'h12345678;
    next_cycle();
    @(negedge clk);
    chk("rg_c1Ready", {31'd0, c1Ready}, 32'd1);
    chk("rg_mWe", {31'd0, mWe}, 32'd1);
    chk("rg_mAddr", mAddr, 32'h20);
    #1 rst = 1'b1;
    #1;
    chk("rg_rst_c1Ready", {31'd0, c1Ready}, 32'd0);
    chk("rg_rst_mWe", {31'd0, mWe}, 32'd0);
    chk("rg_rst_mAddr", mAddr, 32'd0);
    chk("rg_rst_mWData", mWData, 32'd0);
    next_cycle();
    chk("rg_mem_0x20", mem[8], 32'd0);
    @(negedge clk);
    rst = 1'b0; c1Req = 0; c1We = 0;

    // Ten idle cycles with busy-looking but unrequested inputs
    c0Addr = 32'h44; c1Addr = 32'h48; c0We = 1; c1We = 1;
    c0WData = 32'hA5A5A5A5; c1WData = 32'h5A5A5A5A;
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      @(negedge clk);
      chk($sformatf("idle%0d_mWe", i), {31'd0, mWe}, 32'd0);
      chk($sformatf("idle%0d_c0Ready", i), {31'd0, c0Ready}, 32'd0);
      chk($sformatf("idle%0d_c1Ready", i), {31'd0, c1Ready}, 32'd0);
      chk($sformatf("idle%0d_mAddr", i), mAddr, 32'd0);
    end

    // After reset core0 wins the first tie
    next_cycle();
    c0We = 0; c1We = 0; c0Req = 1; c1Req = 1;
    next_cycle();
    @(negedge clk);
    chk("tie_c0Ready", {31'd0, c0Ready}, 32'd1);
    chk("tie_c1Ready", {31'd0, c1Ready}, 32'd0);
    c0Req = 0; c1Req = 0;
    next_cycle();

    // Core0 drops its request while granted: no write, no ready
    c0Req = 1; c0We = 1; c0Addr = 32'h30; c0WData = 32'hCAFEF00D;
    next_cycle();
    c0Req = 0;
    @(negedge clk);
    chk("drop_c0Ready", {31'd0, c0Ready}, 32'd0);
    chk("drop_mWe", {31'd0, mWe}, 32'd0);
    next_cycle();
    c0We = 0;
    chk("drop_mem_0x30", mem[12], 32'd0);
    @(negedge clk);
    chk("drop_after_c0Ready", {31'd0, c0Ready}, 32'd0);
    chk("drop_after_c1Ready", {31'd0, c1Ready}, 32'd0);

`ifdef SM_DMARB_LOCK_EN
    // Lock held: core0 keeps the memory for LOCK_MAX cycles, then core1
    next_cycle();
    c0Req = 1; c0Lock = 1; c0Addr = 32'h10;
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      if (i == 0) c1Req = 1;
      @(negedge clk);
      chk($sformatf("lock%0d_c0Ready", i), {31'd0, c0Ready}, 32'd1);
      chk($sformatf("lock%0d_c1Ready", i), {31'd0, c1Ready}, 32'd0);
    end
    next_cycle();
    @(negedge clk);
    chk("lock_end_c1Ready", {31'd0, c1Ready}, 32'd1);
    chk("lock_end_c0Ready", {31'd0, c0Ready}, 32'd0);
    c0Req = 0; c1Req = 0; c0Lock = 0;
    next_cycle();

    // Lock released early: core1 granted on the third cycle
    c0Req = 1; c0Lock = 1; c1Req = 1;
    next_cycle();
    @(negedge clk);
    chk("rel1_c0Ready", {31'd0, c0Ready}, 32'd1);
    next_cycle();
    c0Lock = 0;
    @(negedge clk);
    chk("rel2_c0Ready", {31'd0, c0Ready}, 32'd1);
    chk("rel2_c1Ready", {31'd0, c1Ready}, 32'd0);
    next_cycle();
    @(negedge clk);
    chk("rel3_c1Ready", {31'd0, c1Ready}, 32'd1);
    chk("rel3_c0Ready", {31'd0, c0Ready}, 32'd0);
    c0Req = 0; c1Req = 0;
    next_cycle();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sm_dm_arbiter.md
Name: sm_dm_arbiter

Overview:
- Two-requester arbiter that shares one single-port data memory (sync write, async read) between the two cpu cores' data ports.
- Replaces direct dual-write-port RAM access; sits between sm_cpu data buses and the shared RAM in the top level.
- Round-robin fairness, request/ready handshake, optional bus lock for atomic multi-access sequences.

Parameters:
- AW, 32, address width of core and memory ports.
- DW, 32, data width.
- LOCK_MAX, 4, max consecutive grant cycles a lock may hold the memory (used only with SM_DMARB_LOCK_EN); range 1..15.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- c0Req  in  1  core0 access request, held until c0Ready
- c0We  in  1  core0 write enable (1 = write, 0 = read)
- c0Addr  in  AW  core0 byte address
- c0WData  in  DW  core0 write data
- c0RData  out  DW  core0 read data, valid while c0Ready
- c0Ready  out  1  core0 access completes this cycle
- c1Req, c1We, c1Addr, c1WData, c1RData, c1Ready: same as core0, for core1
- mAddr  out  AW  memory address
- mWe  out  1  memory write enable
- mWData  out  DW  memory write data
- mRData  in  DW  memory read data (combinational from mAddr)
- c0Lock, c1Lock  in  1  hold grant after current access (only with SM_DMARB_LOCK_EN)

Behaviour:
- Clock clk; reset rst is asynchronous, active-high.
- State register: IDLE, GNT0, GNT1. Also lastOwner (1 bit) and lockCnt.
- Reset: state=IDLE, lastOwner=1 (core0 wins first tie), lockCnt=0. All outputs combinational from state, so reset drives c0Ready=c1Ready=0, mWe=0, mAddr=0, mWData=0, c0RData=c1RData=0.
- IDLE next state:
  - both Req -> GNT to !lastOwner;
  - only one Req -> that core;
  - none -> IDLE.
- In GNTx:
  - mAddr=cxAddr, mWData=cxWData, mWe=cxReq&cxWe;
  - cxReady=cxReq; cxRData=mRData;
  - other core's Ready=0 and RData=0.
- Write commits at the clock edge that ends the GNTx cycle.
- Leaving GNTx:
  - lastOwner<=x;
  - other core Req -> GNTy directly (back-to-back, 1 access/cycle under contention);
  - else -> IDLE.
  - Requester x's Req is ignored in this decision: it must re-arbitrate.
- Latency: Req asserted in cycle N from IDLE -> Ready in cycle N+1. The same core alone issuing back-to-back gets one access per 2 cycles.
- Both requesting continuously -> strict alternation 0,1,0,1.
- Req dropped while in GNTx (protocol violation): no write, no Ready, normal transition.
- Reset asserted mid-grant: outputs return to reset values immediately; no write occurs at the next edge.
- Addresses and data pass through untouched; no alignment or range check.

Optional Feature:
- Macro: SM_DMARB_LOCK_EN.
- Defined:
  - c0Lock/c1Lock ports exist.
  - In GNTx with cxLock=1 and lockCnt<LOCK_MAX-1: stay in GNTx and increment lockCnt; the other core waits.
  - Ready in a locked-hold cycle follows cxReq.
  - On lock release or lockCnt reaching LOCK_MAX-1: normal transition, lockCnt<=0.
  - lockCnt also clears on entering any GNT from IDLE.
- Undefined:
  - No lock ports, no lockCnt.
  - Behaviour exactly as above; LOCK_MAX unused.

Decomposition:
- Package sm_dmarb_pkg holds:
  - state encoding constants: IDLE=2'b00, GNT0=2'b01, GNT1=2'b10;
  - lockCnt width constant (4).
- One sub-module: sm_rr_pick2, a combinational 2-way round-robin picker (req[1:0], lastOwner -> valid, pick).
- Everything else lives in sm_dm_arbiter.

Test Plan:
- Core0 write Req at cycle 1, Addr 0x10, WData 0xDEADBEEF -> cycle 2: mWe=1, mAddr=0x10, c0Ready=1. Then core1 read of 0x10 -> c1RData=0xDEADBEEF with c1Ready one cycle after Req.
- Both Req from cycle 1 after reset, held 6 cycles, re-asserted after each Ready -> Ready order c0,c1,c0,c1,c0 on cycles 2..6; never both Ready in one cycle.
- rst pulsed mid-cycle during GNT1 with c1We=1, Addr 0x20, WData 0x12345678 -> c1Ready and mWe drop immediately; memory word 0x20 unchanged; state IDLE.
- No requests for 10 cycles -> mWe=0, both Ready=0, mAddr=0 throughout.
- SM_DMARB_LOCK_EN, LOCK_MAX=4: c0Lock=1 with c0Req held, c1Req=1 -> c0Ready for 4 consecutive cycles, then GNT1 and c1Ready on the 5th. Repeat with c0Lock dropped after 2 cycles -> c1 granted on cycle 3.
- Core0 drops Req while in GNT0 with c0We=1 -> no memory write, c0Ready=0, arbiter returns to IDLE or GNT1.
